// File: rtl/smg_pkg.sv
// -----------------------------------------------------------------------------
// smg_pkg
// Shared constants and types for the seven-segment multiplex scan controller.
//   SMG_DIGITS   : number of multiplexed digits
//   SMG_SEL_OFF  : active-low digit select with every digit dark
//   SMG_ENC_LAT  : register stages inside the downstream segment encoder; the
//                  digit select is delayed by this many extra cycles so it
//                  lines up with the encoded segments
// -----------------------------------------------------------------------------
package smg_pkg;

  localparam int         SMG_DIGITS  = 6;
  localparam logic [5:0] SMG_SEL_OFF = 6'b111111;
  localparam int         SMG_ENC_LAT = 1;
  localparam int         SMG_IDX_W   = 3;
  localparam logic [SMG_IDX_W-1:0] SMG_IDX_LAST = 3'(SMG_DIGITS - 1);

  typedef logic [SMG_IDX_W-1:0] smg_idx_t;

  // One slot of the select-alignment delay line.
  typedef struct packed {
    logic     vld;    // slot carries a real digit (false while priming out of reset)
    smg_idx_t idx;    // digit index that was on number_data
    logic     blank;  // digit suppressed (leading-zero blanking)
  } smg_stage_t;

  // Active-low one-hot digit select.
  function automatic logic [5:0] smg_sel_n(input smg_idx_t idx);
    return ~(6'b000001 << idx);
  endfunction

  // Nibble k of a 24-bit display word.
  function automatic logic [3:0] smg_nibble(input logic [23:0] data, input smg_idx_t idx);
    return data[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/smg_tick_gen.sv
// -----------------------------------------------------------------------------
// smg_tick_gen
// Digit-rate divider. Counts 0..DIGIT_TICKS-1 and flags the terminal count.
//   DIGIT_TICKS : CLK cycles per digit (>= 4)
//   CLK         : system clock, rising edge
//   RSTn        : asynchronous active-low reset
//   step        : high during the terminal-count cycle
// -----------------------------------------------------------------------------
module smg_tick_gen #(
  parameter int DIGIT_TICKS = 50000
) (
  input  logic CLK,
  input  logic RSTn,
  output logic step
);

  localparam int CNT_W = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_TICKS - 1);

  logic [CNT_W-1:0] tick_cnt_reg;

  assign step = (tick_cnt_reg == CNT_LAST);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      tick_cnt_reg <= '0;
    end else if (step) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/smg_scan_module.sv
// -----------------------------------------------------------------------------
// smg_scan_module
// Six-digit multiplex scan controller for a common-anode 7-segment display.
// Holds a 24-bit value as six nibbles, presents one nibble per digit slot on
// number_data and drives the matching active-low digit select one encoder
// latency later, so select and encoded segments change together.
//
// Ports
//   CLK          in   system clock, rising edge
//   RSTn         in   asynchronous active-low reset
//   disp_data    in   24-bit display value, nibble k = digit k (k=0 rightmost)
//   disp_valid   in   one-cycle strobe, captures disp_data as pending
//   disp_busy    out  a captured value is waiting for the next frame boundary
//   number_data  out  nibble of the current digit (to the segment encoder)
//   scan_sel     out  active-low digit select, bit k = digit k
//   frame_start  out  one-cycle pulse when digit 0 begins a new frame
//
// Build option
//   SMG_LEADING_ZERO_BLANK_EN : when defined, digits 5..1 whose nibble and all
//   higher nibbles are zero keep their select high for their slot. Digit 0 is
//   always driven. Undefined: all digits always driven.
// -----------------------------------------------------------------------------
module smg_scan_module
  import smg_pkg::*;
#(
  parameter int DIGIT_TICKS = 50000
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [23:0] disp_data,
  input  logic        disp_valid,
  output logic        disp_busy,
  output logic [3:0]  number_data,
  output logic [5:0]  scan_sel,
  output logic        frame_start
);

  logic       step;
  logic       boundary;
  smg_idx_t   idx_reg;
  logic [23:0] active_data_reg;
  logic [23:0] pending_data_reg;
  logic        pending_reg;
  logic [SMG_DIGITS-1:0] blank_mask;
  smg_stage_t  sel_pipe_reg [SMG_ENC_LAT];
  smg_stage_t  sel_tail;

  smg_tick_gen #(
    .DIGIT_TICKS (DIGIT_TICKS)
  ) u_tick_gen (
    .CLK  (CLK),
    .RSTn (RSTn),
    .step (step)
  );

  // Last tick of digit 5: the only point where the displayed value may change,
  // which is what keeps a frame from mixing two values.
  assign boundary = step && (idx_reg == SMG_IDX_LAST);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      idx_reg <= '0;
    end else if (step) begin
      idx_reg <= (idx_reg == SMG_IDX_LAST) ? '0 : idx_reg + 1'b1;
    end
  end

  // Double buffer. A strobe landing on the boundary bypasses the pending
  // buffer and is the newest value, so it wins over anything pending.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      active_data_reg  <= '0;
      pending_data_reg <= '0;
      pending_reg      <= 1'b0;
    end else if (boundary) begin
      if (disp_valid) begin
        active_data_reg <= disp_data;
      end else if (pending_reg) begin
        active_data_reg <= pending_data_reg;
      end
      pending_reg <= 1'b0;
    end else if (disp_valid) begin
      pending_data_reg <= disp_data;
      pending_reg      <= 1'b1;
    end
  end

  assign disp_busy = pending_reg;

  // Registered boundary: high in the first cycle of the new frame (idx==0).
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary;
    end
  end

`ifdef SMG_LEADING_ZERO_BLANK_EN
  // Digit k is blank when nibble k and everything above it are zero.
  generate
    for (genvar gi = 0; gi < SMG_DIGITS; gi++) begin : g_blank
      if (gi == 0) begin : g_units
        assign blank_mask[gi] = 1'b0;
      end else begin : g_upper
        assign blank_mask[gi] = ~|active_data_reg[23:4*gi];
      end
    end
  endgenerate
`else
  assign blank_mask = '0;
`endif

  // Stage 1: nibble to the encoder. The select attributes for the same digit
  // enter the delay line in the same cycle so they stay paired with it.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      number_data     <= 4'h0;
      sel_pipe_reg[0] <= '0;
    end else begin
      number_data     <= smg_nibble(active_data_reg, idx_reg);
      sel_pipe_reg[0] <= '{vld: 1'b1, idx: idx_reg, blank: blank_mask[idx_reg]};
    end
  end

  // Extra delay stages for a deeper encoder pipeline (none when latency is 1).
  generate
    for (genvar gi = 1; gi < SMG_ENC_LAT; gi++) begin : g_sel_dly
      always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
          sel_pipe_reg[gi] <= '0;
        end else begin
          sel_pipe_reg[gi] <= sel_pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  assign sel_tail = sel_pipe_reg[SMG_ENC_LAT-1];

  // Final stage: select lands together with the encoder's registered segments.
  // vld is clear until the pipe has primed, which keeps the display dark for
  // the first two cycles after reset.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      scan_sel <= SMG_SEL_OFF;
    end else if (sel_tail.vld && !sel_tail.blank) begin
      scan_sel <= smg_sel_n(sel_tail.idx);
    end else begin
      scan_sel <= SMG_SEL_OFF;
    end
  end

endmodule

// File: tb/tb_smg_scan_module.sv
// -----------------------------------------------------------------------------
// tb_smg_scan_module
// Scoreboard bench for smg_scan_module with DIGIT_TICKS=8. The stimulus
// process pushes expected (cycle, signal, value) entries; a monitor on the
// falling edge pops and compares the entries due in the current cycle.
// Cycle numbers are relative to the cycle in which RSTn was released.
// -----------------------------------------------------------------------------
module tb_smg_scan_module;
  import smg_pkg::*;

  localparam int DT = 8;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic [23:0] disp_data = 24'h0;
  logic        disp_valid = 1'b0;
  logic        disp_busy;
  logic [3:0]  number_data;
  logic [5:0]  scan_sel;
  logic        frame_start;

  smg_scan_module #(
    .DIGIT_TICKS (DT)
  ) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .disp_data   (disp_data),
    .disp_valid  (disp_valid),
    .disp_busy   (disp_busy),
    .number_data (number_data),
    .scan_sel    (scan_sel),
    .frame_start (frame_start)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  localparam int K_SEL = 0, K_NUM = 1, K_BUSY = 2, K_FS = 3;

  typedef struct {
    int         cyc;
    int         kind;
    logic [5:0] val;
    string      name;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int b     = 0;

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%b want=%b", name, cyc - b, act, exp_v);
    end else begin
      $display("ok   %s cycle=%0d val=%b", name, cyc - b, act);
    end
  endtask

  function automatic logic [5:0] sample(input int kind);
    case (kind)
      K_SEL:   return scan_sel;
      K_NUM:   return {2'b00, number_data};
      K_BUSY:  return {5'b0, disp_busy};
      default: return {5'b0, frame_start};
    endcase
  endfunction

  // Monitor: compare every expectation that falls due in this cycle.
  always @(negedge CLK) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        chk(q[i].name, sample(q[i].kind), q[i].val);
        q.delete(i);
      end else if (q[i].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL %s missed cycle=%0d got=none want=%b", q[i].name, q[i].cyc - b, q[i].val);
        q.delete(i);
      end
    end
  end

  task automatic push(input int rel, input int kind, input logic [5:0] val, input string name);
    exp_t e;
    e.cyc  = b + rel;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    q.push_back(e);
  endtask

  function automatic logic [5:0] sel_exp(input int k, input logic [23:0] v);
    logic [5:0] one;
    one = 6'b000001 << k;
`ifdef SMG_LEADING_ZERO_BLANK_EN
    if (k != 0 && (v >> (4 * k)) == 24'h0) return 6'b111111;
`endif
    return ~one;
  endfunction

  // Frame starting (idx becomes 0) at relative cycle f displaying value v.
  // Digit k: nibble on number_data for cycles f+8k+1..f+8k+8, select one later.
  task automatic push_frame(input int f, input logic [23:0] v, input int ndig);
    logic [23:0] sh;
    for (int k = 0; k < ndig; k++) begin
      sh = (v >> (4 * k)) & 24'hF;
      push(f + DT*k + 1,  K_NUM, {2'b00, sh[3:0]}, $sformatf("num_d%0d_first", k));
      push(f + DT*k + DT, K_NUM, {2'b00, sh[3:0]}, $sformatf("num_d%0d_last", k));
      push(f + DT*k + 2,      K_SEL, sel_exp(k, v), $sformatf("sel_d%0d_first", k));
      push(f + DT*k + DT + 1, K_SEL, sel_exp(k, v), $sformatf("sel_d%0d_last", k));
    end
    push(f,     K_FS, 6'd1, "frame_start_pulse");
    push(f + 1, K_FS, 6'd0, "frame_start_end");
  endtask

  // Cycles 0..49 after reset release with active value 0.
  task automatic push_reset_scan();
    for (int c = 0; c < 50; c++) begin
      push(c, K_SEL, (c < 2) ? 6'b111111 : sel_exp(((c - 2) / DT) % 6, 24'h0), "rs_sel");
      push(c, K_NUM, 6'd0, "rs_num");
      push(c, K_FS, (c == 48) ? 6'd1 : 6'd0, "rs_fs");
      push(c, K_BUSY, 6'd0, "rs_busy");
    end
  endtask

  task automatic wait_to(input int rel);
    while (cyc < b + rel) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic strobe(input int rel, input logic [23:0] v);
    wait_to(rel);
    disp_data  = v;
    disp_valid = 1'b1;
    @(posedge CLK);
    #2;
    disp_valid = 1'b0;
    disp_data  = 24'hFFFFFF;
  endtask

  initial begin
    int guard;
    repeat (3) @(posedge CLK);
    #2;
    RSTn = 1'b1;
    b = cyc;

    // 1: reset release, blank for two cycles, scan of zero frame
    push_reset_scan();

    // 2: mid-frame strobe, busy until the boundary, next frame shows it
    push(60, K_BUSY, 6'd0, "t2_busy_pre");
    push(61, K_BUSY, 6'd1, "t2_busy_set");
    push(95, K_BUSY, 6'd1, "t2_busy_hold");
    push(96, K_BUSY, 6'd0, "t2_busy_clr");
    push_frame(96, 24'h123456, 6);
    strobe(60, 24'h123456);

    // 3: two strobes in one frame, last wins; frame 96 stays 123456
    push(101, K_BUSY, 6'd1, "t3_busy_set");
    push(143, K_BUSY, 6'd1, "t3_busy_hold");
    push(144, K_BUSY, 6'd0, "t3_busy_clr");
    push_frame(144, 24'h00BEEF, 6);
    strobe(100, 24'hAAAAAA);
    strobe(110, 24'h00BEEF);

    // 4: strobe exactly on the boundary cycle loads directly
    push(191, K_BUSY, 6'd0, "t4_busy_on_bnd");
    push(192, K_BUSY, 6'd0, "t4_busy_after");
    push_frame(192, 24'h654321, 6);
    strobe(191, 24'h654321);

    // 5: leading-zero values
    push_frame(240, 24'h000050, 6);
    push_frame(288, 24'h000000, 6);
    strobe(200, 24'h000050);
    strobe(250, 24'h000000);

    // 6: reset during digit 3 with a value pending
    push_frame(336, 24'h987654, 3);
    push(361, K_NUM, 6'd7, "t6_num_d3");
    push(362, K_SEL, 6'b110111, "t6_sel_d3");
    push(356, K_BUSY, 6'd1, "t6_busy_pending");
    strobe(300, 24'h987654);
    strobe(355, 24'h111111);
    wait_to(363);
    RSTn = 1'b0;
    #1;
    chk("t6_rst_sel", scan_sel, 6'b111111);
    chk("t6_rst_num", {2'b00, number_data}, 6'd0);
    chk("t6_rst_busy", {5'b0, disp_busy}, 6'd0);
    chk("t6_rst_fs", {5'b0, frame_start}, 6'd0);
    repeat (2) @(posedge CLK);
    #2;
    chk("t6_rst_hold_sel", scan_sel, 6'b111111);
    RSTn = 1'b1;
    b = cyc;
    push_reset_scan();
    push_frame(48, 24'h000000, 6);
    wait_to(100);

    guard = 0;
    while (q.size() > 0 && guard < 200) begin
      @(posedge CLK);
      guard++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d_left want=0_left", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
